// File: rtl/hsv_core_pkg.sv
// Shared definitions for the ctrlstatus interrupt source block:
// cause codes, register map and pending-vector bit positions.
package hsv_core_pkg;

   localparam logic [4:0] IRQ_CAUSE_MSI = 5'd3;
   localparam logic [4:0] IRQ_CAUSE_MTI = 5'd7;
   localparam logic [4:0] IRQ_CAUSE_MEI = 5'd11;

   // Bit positions inside the {MEI, MTI, MSI} pending / enable vectors
   localparam int IRQ_BIT_MSI = 0;
   localparam int IRQ_BIT_MTI = 1;
   localparam int IRQ_BIT_MEI = 2;

   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_MSIP        = 3'd4,
      REG_EXT_EN      = 3'd5,
      REG_EXT_PEND    = 3'd6,
      REG_RSVD        = 3'd7
   } irq_reg_addr_t;

   // Priority MEI > MSI > MTI; zero when nothing is enabled and pending
   function automatic logic [4:0] irq_cause_sel(input logic [2:0] en);
      if (en[IRQ_BIT_MEI]) return IRQ_CAUSE_MEI;
      if (en[IRQ_BIT_MSI]) return IRQ_CAUSE_MSI;
      if (en[IRQ_BIT_MTI]) return IRQ_CAUSE_MTI;
      return 5'd0;
   endfunction

endpackage

// File: rtl/hsv_core_sync_ff.sv
// Multi-stage flop synchroniser for asynchronous level inputs, reset to 0.
// Latency STAGES edges; no flow control.
module hsv_core_sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg <= '0;
      end else begin
         stg <= {stg[STAGES-2:0], d};
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/hsv_core_ctrlstatus_irq.sv
// Machine interrupt sources (external, timer, software) -> level irq + cause.
// irq/cause/mip are one edge behind registered state; no ack, no backpressure.
module hsv_core_ctrlstatus_irq
   import hsv_core_pkg::*;
#(
   parameter int NUM_EXT     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE    = 1
) (
   input  logic               clk_core,
   input  logic               rst_core_n,
   input  logic [NUM_EXT-1:0] ext_irq_i,
   input  logic [2:0]         mie_i,
   input  logic               reg_we,
   input  logic               reg_re,
   input  logic [2:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic [2:0]         mip_o,
   output logic               irq,
   output logic [4:0]         irq_cause
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [NUM_EXT-1:0] ext_sync;
   logic [NUM_EXT-1:0] ext_en;
   logic [63:0]        mtime;
   logic [63:0]        mtime_nxt;
   logic [63:0]        mtimecmp;
   logic               msip;
   logic [PW-1:0]      pcnt;
   logic               tick;
   logic [2:0]         pending;
   logic [2:0]         en;
   logic [31:0]        rd_mux;
   irq_reg_addr_t      addr;

   hsv_core_sync_ff #(
      .WIDTH  (NUM_EXT),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk_core),
      .rst_n (rst_core_n),
      .d     (ext_irq_i),
      .q     (ext_sync)
   );

   assign addr = irq_reg_addr_t'(reg_addr);
   assign tick = (pcnt == PW'(PRESCALE - 1));

   // A half-word write wins over the increment for that half only; no carry crosses halves
   always_comb begin
      mtime_nxt = tick ? (mtime + 64'd1) : mtime;
      if (reg_we && addr == REG_MTIME_LO) mtime_nxt = {mtime[63:32], reg_wdata};
      if (reg_we && addr == REG_MTIME_HI) mtime_nxt = {reg_wdata, mtime_nxt[31:0]};
   end

   assign pending[IRQ_BIT_MEI] = |(ext_sync & ext_en);
   assign pending[IRQ_BIT_MTI] = (mtime >= mtimecmp);
   assign pending[IRQ_BIT_MSI] = msip;
   assign en                   = pending & mie_i;

   always_comb begin
      rd_mux = '0;
      case (addr)
         REG_MTIME_LO:    rd_mux = mtime[31:0];
         REG_MTIME_HI:    rd_mux = mtime[63:32];
         REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
         REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
         REG_MSIP:        rd_mux = {31'd0, msip};
         REG_EXT_EN:      rd_mux = 32'(ext_en);
         REG_EXT_PEND:    rd_mux = 32'(ext_sync);
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         pcnt     <= '0;
         mtime    <= '0;
         mtimecmp <= '1;
         msip     <= 1'b0;
         ext_en   <= '0;
      end else begin
         pcnt  <= tick ? '0 : pcnt + PW'(1);
         mtime <= mtime_nxt;
         if (reg_we) begin
            case (addr)
               REG_MTIMECMP_LO: mtimecmp[31:0]  <= reg_wdata;
               REG_MTIMECMP_HI: mtimecmp[63:32] <= reg_wdata;
               REG_MSIP:        msip            <= reg_wdata[0];
               REG_EXT_EN:      ext_en          <= reg_wdata[NUM_EXT-1:0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         mip_o     <= '0;
         irq       <= 1'b0;
         irq_cause <= '0;
         reg_rdata <= '0;
      end else begin
         mip_o     <= pending;
         irq       <= |en;
         irq_cause <= irq_cause_sel(en);
         if (reg_re) reg_rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_irq.sv
// Bench for hsv_core_ctrlstatus_irq: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the register/timer rules.
module tb_hsv_core_ctrlstatus_irq;

   localparam int NUM_EXT     = 4;
   localparam int SYNC_STAGES = 2;
   localparam int PRESCALE    = 1;

   logic               clk_core = 1'b0;
   logic               rst_core_n = 1'b0;
   logic [NUM_EXT-1:0] ext_irq_i = '0;
   logic [2:0]         mie_i = '0;
   logic               reg_we = 1'b0;
   logic               reg_re = 1'b0;
   logic [2:0]         reg_addr = '0;
   logic [31:0]        reg_wdata = '0;
   logic [31:0]        reg_rdata;
   logic [2:0]         mip_o;
   logic               irq;
   logic [4:0]         irq_cause;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 0;

   hsv_core_ctrlstatus_irq #(
      .NUM_EXT     (NUM_EXT),
      .SYNC_STAGES (SYNC_STAGES),
      .PRESCALE    (PRESCALE)
   ) dut (
      .clk_core   (clk_core),
      .rst_core_n (rst_core_n),
      .ext_irq_i  (ext_irq_i),
      .mie_i      (mie_i),
      .reg_we     (reg_we),
      .reg_re     (reg_re),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .mip_o      (mip_o),
      .irq        (irq),
      .irq_cause  (irq_cause)
   );

   always #5 clk_core = ~clk_core;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: architectural state plus the values outputs must show
   logic [63:0]        m_time, m_cmp;
   logic               m_msip;
   logic [NUM_EXT-1:0] m_en;
   logic [NUM_EXT-1:0] m_hist [SYNC_STAGES];
   int unsigned        m_cyc;
   logic [31:0]        e_rdata;
   logic [2:0]         e_mip;
   logic               e_irq;
   logic [4:0]         e_cause;

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return m_time[31:0];
         3'd1: return m_time[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {31'd0, m_msip};
         3'd5: return 32'(m_en);
         3'd6: return 32'(m_hist[SYNC_STAGES-1]);
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         m_time = '0; m_cmp = '1; m_msip = 0; m_en = '0; m_cyc = 0;
         for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
         e_rdata = '0; e_mip = '0; e_irq = 0; e_cause = '0;
      end else begin
         logic [2:0]  pend, en;
         logic [63:0] nt;
         bit          inc;
         pend  = {|(m_hist[SYNC_STAGES-1] & m_en), m_time >= m_cmp, m_msip};
         en    = pend & mie_i;
         e_mip = pend;
         e_irq = |en;
         e_cause = en[2] ? 5'd11 : en[0] ? 5'd3 : en[1] ? 5'd7 : 5'd0;
         if (reg_re) e_rdata = m_read(reg_addr);
         inc = ((m_cyc % PRESCALE) == PRESCALE - 1);
         m_cyc++;
         nt = inc ? m_time + 64'd1 : m_time;
         if (reg_we) begin
            case (reg_addr)
               3'd0: nt = {m_time[63:32], reg_wdata};
               3'd1: nt = {reg_wdata, nt[31:0]};
               3'd2: m_cmp[31:0]  = reg_wdata;
               3'd3: m_cmp[63:32] = reg_wdata;
               3'd4: m_msip = reg_wdata[0];
               3'd5: m_en = reg_wdata[NUM_EXT-1:0];
               default: ;
            endcase
         end
         m_time = nt;
         for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = ext_irq_i;
      end
   end

   always @(negedge clk_core) begin
      if (chk_on && rst_core_n) begin
         chk("cyc_irq", irq, e_irq);
         chk("cyc_cause", irq_cause, e_cause);
         chk("cyc_mip", mip_o, e_mip);
         chk("cyc_rdata", reg_rdata, e_rdata);
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_we = 1; reg_addr = a; reg_wdata = d;
      @(negedge clk_core);
      reg_we = 0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      reg_re = 1; reg_addr = a;
      @(negedge clk_core);
      reg_re = 0;
      d = reg_rdata;
   endtask

   logic [31:0] v;

   initial begin
      // Reset values
      repeat (3) @(negedge clk_core);
      #1;
      chk("rst_irq", irq, 0);
      chk("rst_cause", irq_cause, 0);
      chk("rst_mip", mip_o, 0);
      chk("rst_rdata", reg_rdata, 0);
      @(negedge clk_core);
      mie_i = 3'b111;
      rst_core_n = 1;
      chk_on = 1;

      // Idle: free-running timer, nothing pending
      repeat (100) @(negedge clk_core);
      chk("idle_irq", irq, 0);
      chk("idle_mip", mip_o, 0);
      rd(3'd0, v);
      chk("mtime_lo_100", v, 100);

      // Timer match and release
      mie_i = 3'b010;
      wr(3'd0, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd50);
      repeat (48) @(negedge clk_core);
      chk("tmr_before", irq, 0);
      @(negedge clk_core);
      chk("tmr_irq", irq, 1);
      chk("tmr_cause", irq_cause, 7);
      wr(3'd3, 32'd1);
      chk("tmr_hold", irq, 1);
      @(negedge clk_core);
      chk("tmr_fall", irq, 0);

      // External line through the synchroniser
      mie_i = 3'b100;
      wr(3'd5, 32'h4);
      ext_irq_i = 4'b0100;
      repeat (2) @(negedge clk_core);
      chk("ext_before", irq, 0);
      @(negedge clk_core);
      chk("ext_irq", irq, 1);
      chk("ext_cause", irq_cause, 11);
      wr(3'd5, 32'h0);
      repeat (2) @(negedge clk_core);
      chk("ext_masked", irq, 0);
      rd(3'd6, v);
      chk("ext_pend", v, 32'h4);

      // All three sources, priority handover with irq held
      mie_i = 3'b111;
      wr(3'd5, 32'h4);
      wr(3'd4, 32'h1);
      wr(3'd3, 32'h0);
      wr(3'd2, 32'h0);
      @(negedge clk_core);
      chk("all_irq", irq, 1);
      chk("all_cause", irq_cause, 11);
      ext_irq_i = '0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk_core);
         chk("drop_ext_irq", irq, 1);
         chk("drop_ext_cause", irq_cause, (i < 3) ? 11 : 3);
      end
      wr(3'd4, 32'h0);
      chk("msi_hold", irq_cause, 3);
      @(negedge clk_core);
      chk("mti_irq", irq, 1);
      chk("mti_cause", irq_cause, 7);

      // 64-bit wrap and half-write on the increment edge
      mie_i = 3'b000;
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd0, 32'hFFFF_FFFE);
      repeat (2) @(negedge clk_core);
      rd(3'd0, v);
      chk("wrap_lo", v, 0);
      rd(3'd1, v);
      chk("wrap_hi", v, 0);
      wr(3'd0, 32'h10);
      wr(3'd1, 32'h5);
      rd(3'd0, v);
      chk("hiwr_lo_inc", v, 32'h11);
      rd(3'd1, v);
      chk("hiwr_hi", v, 32'h5);
      wr(3'd0, 32'hFFFF_FFFF);
      wr(3'd0, 32'h20);
      rd(3'd1, v);
      chk("lowr_no_carry", v, 32'h5);

      // Random traffic checked by the per-cycle compare
      for (int c = 0; c < 3000; c++) begin
         reg_we    = ($urandom_range(0, 3) == 0);
         reg_re    = ($urandom_range(0, 2) == 0);
         reg_addr  = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: reg_wdata = $urandom;
            1: reg_wdata = $urandom_range(0, 200);
            2: reg_wdata = 32'hFFFF_FFFF;
            default: reg_wdata = 32'd0;
         endcase
         if ($urandom_range(0, 9) == 0) ext_irq_i = NUM_EXT'($urandom);
         if ($urandom_range(0, 19) == 0) mie_i = 3'($urandom);
         @(negedge clk_core);
      end
      reg_we = 0; reg_re = 0; ext_irq_i = '0;

      // Asynchronous reset while an interrupt is active
      mie_i = 3'b111;
      wr(3'd4, 32'h1);
      @(negedge clk_core);
      chk("pre_rst_irq", irq, 1);
      #2 rst_core_n = 0;
      #1;
      chk("arst_irq", irq, 0);
      chk("arst_cause", irq_cause, 0);
      chk("arst_mip", mip_o, 0);
      chk("arst_rdata", reg_rdata, 0);
      repeat (2) @(negedge clk_core);
      rst_core_n = 1;
      rd(3'd0, v);
      chk("post_rst_mtime", v, 0);
      rd(3'd4, v);
      chk("post_rst_msip", v, 0);
      rd(3'd2, v);
      chk("post_rst_cmp_lo", v, 32'hFFFF_FFFF);
      rd(3'd3, v);
      chk("post_rst_cmp_hi", v, 32'hFFFF_FFFF);
      rd(3'd5, v);
      chk("post_rst_ext_en", v, 0);
      repeat (3) @(negedge clk_core);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
